// File: rtl/bw_r_irf_win_seq.sv
// Save/restore sequencer for the windowed IRF cells: takes one window request at a
// time and issues spaced save/restore strobes with stable addresses and a write block.
module bw_r_irf_win_seq #(
    parameter int unsigned NWIN = 8,
    parameter int unsigned AW   = 3,
    parameter int unsigned CW   = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          req_vld_i,
    output logic          req_rdy_o,
    input  logic [1:0]    req_op_i,
    input  logic [AW-1:0] req_save_win_i,
    input  logic [AW-1:0] req_rest_win_i,
    output logic          save_o,
    output logic [AW-1:0] save_addr_o,
    output logic          restore_o,
    output logic [AW-1:0] restore_addr_o,
    output logic          wr_block_o,
    output logic          done_o,
    output logic          err_o,
    output logic [CW-1:0] save_cnt_o,
    output logic [CW-1:0] rest_cnt_o
);

    localparam logic [1:0] OP_SAVE = 2'b01;
    localparam logic [1:0] OP_REST = 2'b10;
    localparam logic [1:0] OP_SWAP = 2'b11;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SAVE  = 3'd1,
        SWAIT = 3'd2,
        REST  = 3'd3,
        DONE  = 3'd4
    } state_e;

    state_e        state_q, state_d;
    logic          rdy_q, rdy_d;
    logic          save_q, save_d;
    logic          restore_q, restore_d;
    logic          wr_block_q, wr_block_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          do_rest_q, do_rest_d;
    logic [AW-1:0] save_addr_q, save_addr_d;
    logic [AW-1:0] restore_addr_q, restore_addr_d;
    logic [CW-1:0] save_cnt_q, save_cnt_d;
    logic [CW-1:0] rest_cnt_q, rest_cnt_d;

    logic save_ok_c, rest_ok_c, legal_c, accept_c;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] cnt);
        return (cnt == {CW{1'b1}}) ? cnt : cnt + CW'(1);
    endfunction

    // Only the windows the operation actually uses are range-checked
    always_comb begin
        save_ok_c = 32'(req_save_win_i) < NWIN;
        rest_ok_c = 32'(req_rest_win_i) < NWIN;
        case (req_op_i)
            OP_SAVE: legal_c = save_ok_c;
            OP_REST: legal_c = rest_ok_c;
            OP_SWAP: legal_c = save_ok_c & rest_ok_c;
            default: legal_c = 1'b0;
        endcase
        accept_c = req_vld_i & rdy_q;
    end

    always_comb begin
        state_d        = state_q;
        save_d         = 1'b0;
        restore_d      = 1'b0;
        done_d         = 1'b0;
        err_d          = 1'b0;
        do_rest_d      = do_rest_q;
        save_addr_d    = save_addr_q;
        restore_addr_d = restore_addr_q;
        save_cnt_d     = save_cnt_q;
        rest_cnt_d     = rest_cnt_q;

        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    if (!legal_c) begin
                        err_d = 1'b1;
                    end else if (req_op_i == OP_REST) begin
                        state_d        = REST;
                        restore_d      = 1'b1;
                        restore_addr_d = req_rest_win_i;
                        rest_cnt_d     = sat_inc(rest_cnt_q);
                    end else begin
                        state_d     = SAVE;
                        save_d      = 1'b1;
                        save_addr_d = req_save_win_i;
                        save_cnt_d  = sat_inc(save_cnt_q);
                        // Restoring the window just saved is a no-op, so skip it
                        do_rest_d   = (req_op_i == OP_SWAP) && (req_save_win_i != req_rest_win_i);
                        if (req_op_i == OP_SWAP) begin
                            restore_addr_d = req_rest_win_i;
                        end
                    end
                end
            end
            SAVE: begin
                state_d = SWAIT;
            end
            SWAIT: begin
                if (do_rest_q) begin
                    state_d    = REST;
                    restore_d  = 1'b1;
                    rest_cnt_d = sat_inc(rest_cnt_q);
                end else begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end
            REST: begin
                state_d = DONE;
                done_d  = 1'b1;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        rdy_d      = (state_d == IDLE);
        wr_block_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q        <= IDLE;
            rdy_q          <= 1'b0;
            save_q         <= 1'b0;
            restore_q      <= 1'b0;
            wr_block_q     <= 1'b0;
            done_q         <= 1'b0;
            err_q          <= 1'b0;
            do_rest_q      <= 1'b0;
            save_addr_q    <= '0;
            restore_addr_q <= '0;
            save_cnt_q     <= '0;
            rest_cnt_q     <= '0;
        end else begin
            state_q        <= state_d;
            rdy_q          <= rdy_d;
            save_q         <= save_d;
            restore_q      <= restore_d;
            wr_block_q     <= wr_block_d;
            done_q         <= done_d;
            err_q          <= err_d;
            do_rest_q      <= do_rest_d;
            save_addr_q    <= save_addr_d;
            restore_addr_q <= restore_addr_d;
            save_cnt_q     <= save_cnt_d;
            rest_cnt_q     <= rest_cnt_d;
        end
    end

    assign req_rdy_o      = rdy_q;
    assign save_o         = save_q;
    assign restore_o      = restore_q;
    assign wr_block_o     = wr_block_q;
    assign done_o         = done_q;
    assign err_o          = err_q;
    assign save_addr_o    = save_addr_q;
    assign restore_addr_o = restore_addr_q;
    assign save_cnt_o     = save_cnt_q;
    assign rest_cnt_o     = rest_cnt_q;

endmodule

// File: tb/tb_bw_r_irf_win_seq.sv
// Bench for bw_r_irf_win_seq: vector table plus hand sequences, strobes checked
// against a queue of expected events with their exact cycle and address.
module tb_bw_r_irf_win_seq;

    localparam int unsigned NWIN = 7;
    localparam int unsigned AW   = 3;
    localparam int unsigned CW   = 4;
    localparam int          SAT  = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_vld;
    logic          req_rdy;
    logic [1:0]    req_op;
    logic [AW-1:0] req_save_win;
    logic [AW-1:0] req_rest_win;
    logic          save;
    logic [AW-1:0] save_addr;
    logic          restore;
    logic [AW-1:0] restore_addr;
    logic          wr_block;
    logic          done;
    logic          err;
    logic [CW-1:0] save_cnt;
    logic [CW-1:0] rest_cnt;

    bw_r_irf_win_seq #(.NWIN(NWIN), .AW(AW), .CW(CW)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .req_vld_i      (req_vld),
        .req_rdy_o      (req_rdy),
        .req_op_i       (req_op),
        .req_save_win_i (req_save_win),
        .req_rest_win_i (req_rest_win),
        .save_o         (save),
        .save_addr_o    (save_addr),
        .restore_o      (restore),
        .restore_addr_o (restore_addr),
        .wr_block_o     (wr_block),
        .done_o         (done),
        .err_o          (err),
        .save_cnt_o     (save_cnt),
        .rest_cnt_o     (rest_cnt)
    );

    always #5 clk = ~clk;

    localparam int EV_SAVE = 0;
    localparam int EV_REST = 1;
    localparam int EV_DONE = 2;
    localparam int EV_ERR  = 3;

    typedef struct {
        int kind;
        int addr;
        int cyc;
    } ev_t;

    typedef struct {
        logic [1:0] op;
        logic [2:0] sw;
        logic [2:0] rw;
        logic       exp_err;
        int         exp_len;
    } vec_t;

    ev_t  exp_q[$];
    vec_t vecs[10];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   wb_cnt = 0;
    int   m_sa = 0, m_ra = 0, m_sc = 0, m_rc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_ev(input int kind, input int addr, input int c);
        ev_t e;
        e.kind = kind;
        e.addr = addr;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    task automatic got_ev(input int kind, input int addr);
        ev_t e;
        if (exp_q.size() == 0) begin
            chk("unexpected_event", kind, -1);
        end else begin
            e = exp_q.pop_front();
            chk("event_kind", kind, e.kind);
            chk("event_addr", addr, e.addr);
            chk("event_cycle", cyc, e.cyc);
        end
    endtask

    // Observed strobes are matched in order against the expected-event queue
    always @(negedge clk) begin
        if (wr_block) begin
            wb_cnt++;
            chk("save_addr_stable", int'(save_addr), m_sa);
            chk("restore_addr_stable", int'(restore_addr), m_ra);
        end
        if (save && restore) chk("save_restore_overlap", 1, 0);
        if (save)    got_ev(EV_SAVE, int'(save_addr));
        if (restore) got_ev(EV_REST, int'(restore_addr));
        if (done)    got_ev(EV_DONE, 0);
        if (err)     got_ev(EV_ERR, 0);
    end

    function automatic int sat(input int v);
        return (v >= SAT) ? SAT : v + 1;
    endfunction

    // Called at a negedge; returns at the negedge where the sequencer is ready again
    task automatic issue(input logic [1:0] op, input logic [2:0] sw, input logic [2:0] rw,
                         input logic exp_err, input int exp_len);
        int a, w, wb0;
        req_op = op;
        req_save_win = sw;
        req_rest_win = rw;
        req_vld = 1'b1;
        w = 0;
        while (!req_rdy && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!req_rdy) begin
            chk("accept_timeout", 0, 1);
            req_vld = 1'b0;
            return;
        end
        a = cyc + 1;
        if (exp_err) begin
            push_ev(EV_ERR, 0, a);
        end else if (op == 2'b01) begin
            push_ev(EV_SAVE, int'(sw), a);
            push_ev(EV_DONE, 0, a + 2);
        end else if (op == 2'b10) begin
            push_ev(EV_REST, int'(rw), a);
            push_ev(EV_DONE, 0, a + 1);
        end else if (sw != rw) begin
            push_ev(EV_SAVE, int'(sw), a);
            push_ev(EV_REST, int'(rw), a + 2);
            push_ev(EV_DONE, 0, a + 3);
        end else begin
            push_ev(EV_SAVE, int'(sw), a);
            push_ev(EV_DONE, 0, a + 2);
        end
        @(posedge clk);
        #1;
        if (exp_err) begin
            req_vld = 1'b0;
        end else begin
            // Keep an illegal request pending while busy; it must be ignored
            req_op = 2'b00;
            req_save_win = 3'd7;
            req_rest_win = 3'd7;
            if (op[0]) begin m_sa = int'(sw); m_sc = sat(m_sc); end
            if (op[1]) m_ra = int'(rw);
            if (op == 2'b10 || (op == 2'b11 && sw != rw)) m_rc = sat(m_rc);
        end
        wb0 = wb_cnt;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!req_rdy && w < 20);
        req_vld = 1'b0;
        chk("rdy_latency", cyc - a, exp_len);
        chk("wr_block_cycles", wb_cnt - wb0, exp_len);
        chk("save_cnt", int'(save_cnt), m_sc);
        chk("rest_cnt", int'(rest_cnt), m_rc);
        chk("save_addr", int'(save_addr), m_sa);
        chk("restore_addr", int'(restore_addr), m_ra);
    endtask

    initial begin
        int a;
        vecs[0] = '{2'b01, 3'd5, 3'd0, 1'b0, 3};  // SAVE 5
        vecs[1] = '{2'b11, 3'd2, 3'd6, 1'b0, 4};  // SWAP 2/6
        vecs[2] = '{2'b11, 3'd3, 3'd3, 1'b0, 3};  // SWAP same window
        vecs[3] = '{2'b00, 3'd1, 3'd1, 1'b1, 0};  // illegal op
        vecs[4] = '{2'b10, 3'd0, 3'd7, 1'b1, 0};  // RESTORE out of range
        vecs[5] = '{2'b01, 3'd7, 3'd0, 1'b1, 0};  // SAVE out of range
        vecs[6] = '{2'b11, 3'd6, 3'd7, 1'b1, 0};  // SWAP restore out of range
        vecs[7] = '{2'b10, 3'd0, 3'd6, 1'b0, 2};  // RESTORE top window
        vecs[8] = '{2'b10, 3'd4, 3'd0, 1'b0, 2};  // RESTORE 0
        vecs[9] = '{2'b11, 3'd0, 3'd6, 1'b0, 4};  // SWAP 0/6

        rst = 1'b1;
        req_vld = 1'b0;
        req_op = 2'b00;
        req_save_win = '0;
        req_rest_win = '0;
        #1;
        chk("reset_rdy", int'(req_rdy), 0);
        chk("reset_strobes", int'({save, restore, wr_block, done, err}), 0);
        chk("reset_addrs", int'({save_addr, restore_addr}), 0);
        chk("reset_cnts", int'({save_cnt, rest_cnt}), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rdy_after_release", int'(req_rdy), 1);

        foreach (vecs[i]) issue(vecs[i].op, vecs[i].sw, vecs[i].rw, vecs[i].exp_err, vecs[i].exp_len);

        // Reset during SWAIT of a SWAP: no restore may follow
        req_op = 2'b11;
        req_save_win = 3'd2;
        req_rest_win = 3'd6;
        req_vld = 1'b1;
        a = cyc + 1;
        push_ev(EV_SAVE, 2, a);
        @(posedge clk);
        #1;
        req_vld = 1'b0;
        m_sa = 2;
        m_ra = 6;
        m_sc = sat(m_sc);
        @(negedge clk);
        @(negedge clk);
        chk("swait_wr_block", int'(wr_block), 1);
        #2;
        rst = 1'b1;
        m_sa = 0; m_ra = 0; m_sc = 0; m_rc = 0;
        #1;
        chk("async_rst_strobes", int'({save, restore, wr_block, done, err}), 0);
        chk("async_rst_rdy", int'(req_rdy), 0);
        chk("async_rst_addrs", int'({save_addr, restore_addr}), 0);
        chk("async_rst_cnts", int'({save_cnt, rest_cnt}), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        issue(2'b01, 3'd4, 3'd0, 1'b0, 3);

        // Back-to-back saves run the save counter into saturation
        for (int i = 0; i < 16; i++) issue(2'b01, 3'(i % 7), 3'd0, 1'b0, 3);
        chk("save_cnt_saturated", int'(save_cnt), SAT);
        issue(2'b11, 3'd1, 3'd5, 1'b0, 4);

        repeat (5) @(negedge clk);
        chk("events_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bw_r_irf_win_seq.md
Name: bw_r_irf_win_seq

Overview:
- Save/restore sequencer that drives the save/restore side of the per-register windowed IRF cells: save, save_addr, restore, restore_addr.
- Takes one window-operation request at a time (save, restore, or swap) from trap/window-control logic.
- Issues correctly spaced save/restore strobes with addresses held stable, blocks architectural IRF writes while busy, and reports completion.
- Sits between window-control logic and the IRF register array; one instance fans out to all register cells.

Parameters:
- NWIN, 8, number of implemented windows; legal window indices 0..NWIN-1.
- AW, 3, window index width.
- CW, 16, width of saturating operation counters.

Ports:
- clk  in  1  core clock; all state on posedge.
- rst  in  1  asynchronous, active-high reset.
- req_vld  in  1  request valid.
- req_rdy  out  1  sequencer can accept; transfer when req_vld & req_rdy at posedge.
- req_op  in  2  01=SAVE, 10=RESTORE, 11=SWAP (save then restore), 00=illegal.
- req_save_win  in  AW  window to save into (SAVE, SWAP).
- req_rest_win  in  AW  window to restore from (RESTORE, SWAP).
- save  out  1  save strobe to IRF cells.
- save_addr  out  AW  save window index.
- restore  out  1  restore strobe to IRF cells.
- restore_addr  out  AW  restore window index.
- wr_block  out  1  suppress architectural IRF wren while high.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse on rejected request.
- save_cnt  out  CW  saturating count of issued save strobes.
- rest_cnt  out  CW  saturating count of issued restore strobes.

Behaviour:
- All outputs are registered.
- Reset values: req_rdy=0 while rst asserted, 1 the first cycle after release; save=0, restore=0, save_addr=0, restore_addr=0, wr_block=0, done=0, err=0, counters=0. State=IDLE.
- States: IDLE, SAVE, SWAIT, REST, DONE.
- req_rdy=1 only in IDLE with rst low.
- Accept edge is E0. Request is validated at accept.
  - Illegal op, or any used window index >= NWIN: err=1 for the cycle after E0; state stays IDLE; no strobes; addresses unchanged.
- Operation sequences (E0 = accept edge; Ek = k-th posedge after it):
  - SAVE: after E0 in SAVE (save=1, save_addr=req_save_win); after E1 in SWAIT (save=0); after E2 in DONE (done=1); after E3 in IDLE.
  - RESTORE: after E0 in REST (restore=1, restore_addr=req_rest_win); after E1 in DONE; after E2 in IDLE.
  - SWAP: SAVE → SWAIT → REST → DONE → IDLE. restore_addr is loaded at entry to SAVE.
  - SWAP with req_save_win == req_rest_win: REST is skipped (SWAIT → DONE). Restoring the same window just saved is a no-op in the cells.
- SWAIT exists so the save completes (window written on the following negedge) before any restore strobe.
- save_addr and restore_addr hold their last value in every state. They change only at accept of a legal request, never mid-sequence.
- save and restore are never high in the same cycle. Each is high exactly one cycle per issue.
- wr_block = 1 in SAVE, SWAIT, REST and DONE; 0 in IDLE.
- save_cnt increments on entry to SAVE; rest_cnt increments on entry to REST. Both saturate at 2^CW-1 and do not wrap.
- req_vld while busy: ignored, not queued (req_rdy=0). The requester holds until accepted.
- Asynchronous rst mid-operation: immediately go to IDLE and clear save, restore, wr_block, done, err. Counters and addresses also reset. An interrupted sequence is not resumed.
- Back-to-back requests: the earliest next accept is the edge after DONE (state IDLE).

Test Plan:
- SAVE win 5 → save=1 one cycle with save_addr=5; done pulses 2 cycles after the save cycle; wr_block high 3 cycles; save_cnt=1, rest_cnt=0.
- SWAP save 2 / restore 6 → save (addr 2), one idle cycle, restore (addr 6), done; save_addr=2 and restore_addr=6 stable throughout; wr_block high 4 cycles; both counters=1.
- SWAP save 3 / restore 3 → save only, no restore strobe; done 2 cycles after save; rest_cnt unchanged.
- req_op=00, then RESTORE win 7 with NWIN=6 → err pulse each time; no strobes; req_rdy stays 1; counters unchanged.
- rst asserted during SWAIT of a SWAP → save/restore/wr_block drop asynchronously; no restore is issued; first accept after release behaves as from reset.
- Force save_cnt to 0xFFFE, issue 3 SAVEs → save_cnt reads 0xFFFF, no wrap.
